// File: rtl/irq_timer.sv
// irq_timer: memory-mapped countdown timer that raises a hardware interrupt.
// Registers: CTRL (addr 0), PRESET (addr 1) and a read-only COUNT (addr 2).
// One-shot mode holds a level interrupt until software writes CTRL or PRESET.
// Auto-reload mode emits a one-cycle pulse every PRESET+2 cycles.
module irq_timer #(
    parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_CNT  = 2'b10,
        S_INT  = 2'b11
    } state_e;

    localparam logic [1:0] MODE_AUTO = 2'b01;

    state_e      state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pend_q, pend_d;

    logic        wr_ctrl_s;
    logic        wr_preset_s;
    logic        hw_set_s;

    assign wr_ctrl_s   = we & (addr == 2'd0);
    assign wr_preset_s = we & (addr == 2'd1);

    // Masked interrupt: the pending flag only reaches HWInt when IM is set.
    assign irq = im_q & pend_q;

    // Combinational register read mux.
    always_comb begin
        rdata = 32'h0000_0000;
        case (addr)
            2'd0:    rdata = {28'h000_0000, im_q, mode_q, en_q};
            2'd1:    rdata = preset_q;
            2'd2:    rdata = count_q;
            default: rdata = 32'h0000_0000;
        endcase
    end

    // Next-state logic: FSM update first, then software writes layered on top.
    // Software CTRL writes override the one-shot EN clear; a hardware set of
    // the pending flag overrides a same-cycle software acknowledge.
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_d   = pend_q;
        hw_set_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en_q) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d  = 32'd0;
                    pend_d   = 1'b1;
                    hw_set_s = 1'b1;
                    state_d  = S_INT;
                end
            end
            S_INT: begin
                if (mode_q == MODE_AUTO) begin
                    pend_d  = 1'b0;
                    state_d = S_LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (wr_ctrl_s) begin
            en_d   = wdata[0];
            mode_d = wdata[2:1];
            im_d   = wdata[3];
        end else begin
            en_d = en_d;
        end

        if (wr_preset_s) begin
            preset_d = wdata;
        end else begin
            preset_d = preset_d;
        end

        if ((wr_ctrl_s || wr_preset_s) && !hw_set_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_d;
        end
    end

    // State and register flops with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            mode_q   <= 2'b00;
            im_q     <= 1'b0;
            preset_q <= PRESET_RST;
            count_q  <= 32'd0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
        end
    end

endmodule

// File: tb/tb_irq_timer.sv
// Scoreboard bench for irq_timer: a stimulus process drives bus cycles and
// queues the expected read data / irq from a behavioural timer model; a
// monitor process pops and compares on every falling edge.
module tb_irq_timer;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    irq_timer #(.PRESET_RST(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        irq;
        logic [1:0]  addr;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_n = 0;

    // Behavioural model of the timer, in terms of what software sees.
    localparam int PH_IDLE  = 0;
    localparam int PH_LOAD  = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_FIRED = 3;

    int          m_phase;
    logic        m_en;
    logic [1:0]  m_mode;
    logic        m_im;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_pend;

    function automatic void model_reset();
        m_phase  = PH_IDLE;
        m_en     = 1'b0;
        m_mode   = 2'b00;
        m_im     = 1'b0;
        m_preset = 32'h0000_0000;
        m_count  = 32'd0;
        m_pend   = 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] v;
        v = 32'd0;
        if (a == 2'd0) v = {28'd0, m_im, m_mode, m_en};
        else if (a == 2'd1) v = m_preset;
        else if (a == 2'd2) v = m_count;
        return v;
    endfunction

    function automatic void model_edge(input logic w, input logic [1:0] a, input logic [31:0] d);
        logic fired;
        fired = 1'b0;
        if (m_phase == PH_IDLE) begin
            if (m_en) m_phase = PH_LOAD;
        end else if (m_phase == PH_LOAD) begin
            m_count = m_preset;
            m_phase = PH_RUN;
        end else if (m_phase == PH_RUN) begin
            if (!m_en) m_phase = PH_IDLE;
            else if (m_count > 32'd1) m_count = m_count - 32'd1;
            else begin
                m_count = 32'd0;
                m_pend  = 1'b1;
                fired   = 1'b1;
                m_phase = PH_FIRED;
            end
        end else begin
            if (m_mode == 2'b01) begin
                m_pend  = 1'b0;
                m_phase = PH_LOAD;
            end else begin
                m_en    = 1'b0;
                m_phase = PH_IDLE;
            end
        end
        if (w && a == 2'd0) {m_im, m_mode, m_en} = d[3:0];
        if (w && a == 2'd1) m_preset = d;
        if (w && (a == 2'd0 || a == 2'd1) && !fired) m_pend = 1'b0;
    endfunction

    // One bus cycle: drive inputs, queue expectations, advance the model.
    task automatic cycle(input logic w, input logic [1:0] a, input logic [31:0] d);
        exp_t e;
        we    = w;
        addr  = a;
        wdata = d;
        e.rdata = model_read(a);
        e.irq   = m_im & m_pend;
        e.addr  = a;
        e.cyc   = cyc_n;
        exp_q.push_back(e);
        model_edge(w, a, d);
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd2, 32'd0);
    endtask

    // Monitor: compare DUT outputs against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (rdata !== e.rdata) begin
                    n_bad++;
                    $display("FAIL rdata cyc=%0d addr=%0d got=%h exp=%h", e.cyc, e.addr, rdata, e.rdata);
                end
                n_cmp++;
                if (irq !== e.irq) begin
                    n_bad++;
                    $display("FAIL irq cyc=%0d got=%b exp=%b", e.cyc, irq, e.irq);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic direct_check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, want);
        end
    endtask

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        int unsigned r;
        logic [31:0] d;
        reset = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset values.
        cycle(1'b0, 2'd0, 32'd0);
        cycle(1'b0, 2'd1, 32'd0);
        cycle(1'b0, 2'd2, 32'd0);

        // One-shot with acknowledge.
        cycle(1'b1, 2'd1, 32'd5);
        cycle(1'b1, 2'd0, 32'h9);
        idle(9);
        cycle(1'b0, 2'd0, 32'd0);
        cycle(1'b1, 2'd0, 32'h8);
        idle(3);

        // Auto-reload, then shorten the period mid-run.
        cycle(1'b1, 2'd1, 32'd3);
        cycle(1'b1, 2'd0, 32'hB);
        idle(22);
        cycle(1'b1, 2'd1, 32'd1);
        idle(12);
        cycle(1'b1, 2'd0, 32'h0);
        idle(2);

        // Masked expiry, then IM set by a CTRL write (which acknowledges).
        cycle(1'b1, 2'd1, 32'd2);
        cycle(1'b1, 2'd0, 32'h1);
        idle(8);
        cycle(1'b1, 2'd0, 32'h8);
        idle(3);
        cycle(1'b1, 2'd0, 32'h1);
        idle(8);
        cycle(1'b1, 2'd0, 32'h9);
        idle(8);
        cycle(1'b1, 2'd0, 32'h0);

        // Disable mid-count, then re-enable.
        cycle(1'b1, 2'd1, 32'd10);
        cycle(1'b1, 2'd0, 32'h1);
        idle(6);
        cycle(1'b1, 2'd0, 32'h0);
        idle(4);
        cycle(1'b1, 2'd0, 32'h1);
        idle(4);
        cycle(1'b1, 2'd0, 32'h0);
        idle(2);

        // Race: acknowledge on the same edge as expiry; COUNT writes ignored.
        cycle(1'b1, 2'd1, 32'd2);
        cycle(1'b1, 2'd0, 32'h9);
        idle(3);
        cycle(1'b1, 2'd0, 32'h9);
        cycle(1'b1, 2'd2, 32'h1234_5678);
        cycle(1'b1, 2'd3, 32'hFFFF_FFFF);
        idle(3);
        cycle(1'b1, 2'd0, 32'h8);

        // Asynchronous reset during a count, with no clock edge.
        cycle(1'b1, 2'd1, 32'd20);
        cycle(1'b1, 2'd0, 32'h9);
        idle(5);
        we   = 1'b0;
        addr = 2'd2;
        #2;
        reset = 1'b0;
        #1;
        direct_check("async_count", rdata, 32'd0);
        direct_check("async_irq", {31'd0, irq}, 32'd0);
        addr = 2'd0;
        #1;
        direct_check("async_ctrl", rdata, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                cycle(1'b1, 2'd1, 32'($urandom_range(0, 6)));
            end else if (r < 16) begin
                d = 32'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                cycle(1'b1, 2'd0, d);
            end else if (r < 20) begin
                cycle(1'b1, 2'($urandom_range(2, 3)), $urandom);
            end else begin
                cycle(1'b0, 2'($urandom_range(0, 3)), $urandom);
            end
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
